// File: rtl/cpu_seq_ctl.sv
// Multi-cycle instruction sequencer: steps fetch/decode/exec/mem/wb and drives datapath strobes.
// Strobes are forced low while RSTN is asserted so nothing leaks out during reset.
module cpu_seq_ctl #(
    parameter bit RESET_PC_SRC = 1'b0
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [2:0]  OPCLASS,
    input  logic        BR_TAKEN,
    input  logic        MEM_READY,
    output logic [1:0]  OP1_CTL,
    output logic        IR_WE,
    output logic        PC_WE,
    output logic        PC_SRC,
    output logic        RF_WE,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [2:0]  STATE,
    output logic        HALTED,
    output logic [31:0] INSTRET
);

    // Operand-1 select codes, matching the datapath mux encoding in defs.v.
    localparam logic [1:0] OP1_SRC_PC   = 2'd0;
    localparam logic [1:0] OP1_SRC_INST = 2'd1;
    localparam logic [1:0] OP1_SRC_RD   = 2'd2;

    localparam logic [2:0] ClsUpper  = 3'd2;
    localparam logic [2:0] ClsLoad   = 3'd3;
    localparam logic [2:0] ClsStore  = 3'd4;
    localparam logic [2:0] ClsBranch = 3'd5;
    localparam logic [2:0] ClsJump   = 3'd6;
    localparam logic [2:0] ClsHalt   = 3'd7;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  class_q, class_d;
    logic [31:0] instret_q, instret_d;
    logic [1:0]  op1_exec, op1_ctl;
    logic        ir_we, pc_we, pc_src, rf_we, mem_req, mem_we, halted;

    always_comb begin
        unique case (class_q)
            ClsUpper:           op1_exec = OP1_SRC_INST;
            ClsBranch, ClsJump: op1_exec = OP1_SRC_PC;
            default:            op1_exec = OP1_SRC_RD;
        endcase
    end

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_src  = RESET_PC_SRC;
        rf_we   = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        halted  = 1'b0;
        op1_ctl = OP1_SRC_PC;
        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (MEM_READY) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                class_d = OPCLASS;
                state_d = StExec;
            end
            StExec: begin
                op1_ctl = op1_exec;
                case (class_q)
                    ClsLoad, ClsStore: state_d = StMem;
                    ClsBranch: begin
                        pc_we   = 1'b1;
                        pc_src  = BR_TAKEN;
                        state_d = StFetch;
                    end
                    ClsHalt: state_d = StHalt;
                    default: state_d = StWb;
                endcase
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = (class_q == ClsStore);
                op1_ctl = OP1_SRC_RD;
                if (MEM_READY) begin
                    if (class_q == ClsStore) begin
                        pc_we   = 1'b1;
                        pc_src  = 1'b0;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                pc_src  = (class_q == ClsJump);
                op1_ctl = op1_exec;
                state_d = StFetch;
            end
            StHalt: halted = 1'b1;
            default: state_d = StFetch;
        endcase
    end

    // Every PC update is exactly one retired instruction.
    assign instret_d = instret_q + {31'd0, pc_we};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= StFetch;
            class_q   <= 3'd0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            instret_q <= instret_d;
        end
    end

    assign OP1_CTL = op1_ctl;
    assign IR_WE   = ir_we & RSTN;
    assign PC_WE   = pc_we & RSTN;
    assign PC_SRC  = pc_src;
    assign RF_WE   = rf_we & RSTN;
    assign MEM_REQ = mem_req & RSTN;
    assign MEM_WE  = mem_we & RSTN;
    assign STATE   = state_q;
    assign HALTED  = halted;
    assign INSTRET = instret_q;

endmodule
